mem_port_arbiter: RTL

- Shares one single-ported memory between the core's instruction-fetch side and its load/store side.
- Holds the last fetched word in a one-entry tagged buffer and keeps it valid while the core's pc still points at it. A multi-cycle load/store therefore sees a stable instruction until the access completes.
- Sits between the cpu ports (pc/instruction/instr_valid and address/read_*/write_*) and the memory model or bus bridge.
- Includes a per-transaction timeout that aborts the transaction and retries.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with a one-entry tagged instruction buffer and a per-transaction timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_instr,
  output logic        if_valid,
  input  logic [31:0] d_addr,
  input  logic        d_read_enable,
  input  logic        d_write_enable,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_wready,
  output logic [31:0] mem_addr,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_wready,
  output logic        bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       fetch_addr;
  logic [31:0]       fetch_tag;
  logic [31:0]       buf_instr;
  logic [31:0]       buf_tag;
  logic              buf_valid;
  logic [CNT_W-1:0]  tmo_cnt;

  logic d_req;
  logic fetch_done;
  logic data_done;
  logic tmo_hit;
  logic store_hit;

  assign if_valid = buf_valid && (buf_tag == if_addr);
  assign if_instr = buf_instr;
  assign d_rdata  = mem_rdata;

  assign d_req      = d_read_enable || d_write_enable;
  assign fetch_done = (state == FETCH) && mem_rvalid;
  assign data_done  = (state == DATA) &&
                      ((mem_rvalid && d_read_enable) || (mem_wready && d_write_enable));
  // Timeout only fires while a request is still waiting; completion takes priority.
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST) &&
                      (((state == FETCH) && !mem_rvalid) ||
                       ((state == DATA) && d_req && !data_done));
  // A completing store into the buffered word invalidates the buffer.
  assign store_hit  = (state == DATA) && mem_wready && d_write_enable &&
                      (d_addr[31:2] == buf_tag[31:2]);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: data side has priority over fetch in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req) begin
          state_next = DATA;
        end else if (if_req && !if_valid) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (fetch_done || tmo_hit) begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (data_done || !d_req || tmo_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side and data-return outputs per state.
  always_comb begin
    mem_addr         = 32'h0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_wdata        = 32'h0;
    mem_wstrb        = 4'h0;
    d_rvalid         = 1'b0;
    d_wready         = 1'b0;
    case (state)
      FETCH: begin
        mem_addr        = fetch_addr;
        mem_read_enable = 1'b1;
      end
      DATA: begin
        mem_addr         = d_addr;
        mem_read_enable  = d_read_enable;
        mem_write_enable = d_write_enable;
        mem_wdata        = d_wdata;
        mem_wstrb        = d_wstrb;
        d_rvalid         = mem_rvalid && d_read_enable;
        d_wready         = mem_wready && d_write_enable;
      end
      default: ;
    endcase
  end

  // Fetch target latch, instruction buffer, timeout counter and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr <= 32'h0;
      fetch_tag  <= 32'h0;
      buf_instr  <= 32'h0;
      buf_tag    <= 32'h0;
      buf_valid  <= 1'b0;
      tmo_cnt    <= '0;
      bus_error  <= 1'b0;
    end else begin
      bus_error <= tmo_hit;
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if ((state == IDLE) && !d_req && if_req && !if_valid) begin
        fetch_addr <= {if_addr[31:2], 2'b00};
        fetch_tag  <= if_addr;
      end
      if (fetch_done) begin
        buf_instr <= mem_rdata;
        buf_tag   <= fetch_tag;
        buf_valid <= 1'b1;
      end else if (store_hit) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule
